// File: rtl/keypad_emulator.sv
// Row-side emulation of a 4x4 matrix keypad: answers the scanner's column drive
// with a commanded key closure, hold time and optional LFSR-driven contact bounce.
module keypad_emulator #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned BOUNCE_EN = 1,
    parameter int unsigned BOUNCE_MS = 4,
    parameter int unsigned GAP_MS    = 30
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold_ms,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HOLD,
        S_BOUNCE_OUT,
        S_GAP
    } state_t;

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [15:0]   BOUNCE_LIM = 16'(BOUNCE_MS);
    localparam logic [15:0]   GAP_LIM    = 16'(GAP_MS);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_q, ms_d;
    logic [3:0]    key_q, key_d;
    logic [15:0]   hold_q, hold_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [3:0]    row_q, row_d;

    logic        accept;
    logic        tick;
    logic        last;
    logic        contact;
    logic        bouncing;
    logic [15:0] limit;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q + PW'(1);
        ms_d     = ms_q;
        key_d    = key_q;
        hold_d   = hold_q;
        lfsr_d   = lfsr_q;
        row_d    = 4'hF;
        contact  = 1'b0;
        limit    = 16'd1;
        done     = 1'b0;

        accept   = cmd_valid && (state_q == S_IDLE);
        tick     = (presc_q == PRESC_MAX);
        bouncing = (state_q == S_BOUNCE_IN) || (state_q == S_BOUNCE_OUT);

        case (state_q)
            S_BOUNCE_IN, S_BOUNCE_OUT: limit = BOUNCE_LIM;
            S_HOLD:                    limit = hold_q;
            S_GAP:                     limit = GAP_LIM;
            default:                   limit = 16'd1;
        endcase
        last = tick && (ms_q == limit - 16'd1);

        if (tick) begin
            presc_d = '0;
        end
        if (state_q != S_IDLE && tick) begin
            ms_d = last ? '0 : ms_q + 16'd1;
        end
        if (tick && bouncing) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    presc_d = '0;
                    ms_d    = '0;
                    key_d   = cmd_key;
                    hold_d  = (cmd_hold_ms == 16'd0) ? 16'd1 : cmd_hold_ms;
                    state_d = (BOUNCE_EN != 0) ? S_BOUNCE_IN : S_HOLD;
                end
            end
            S_BOUNCE_IN: begin
                contact = lfsr_q[0];
                if (last) state_d = S_HOLD;
            end
            S_HOLD: begin
                contact = 1'b1;
                if (last) state_d = (BOUNCE_EN != 0) ? S_BOUNCE_OUT : S_GAP;
            end
            S_BOUNCE_OUT: begin
                contact = lfsr_q[0];
                if (last) state_d = S_GAP;
            end
            S_GAP: begin
                if (last) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Column index is key[1:0]; row index counts from the bottom: r = 3 - key[3:2].
        if (contact && !col[key_q[1:0]]) begin
            row_d = ~(4'b0001 << (2'd3 - key_q[3:2]));
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            ms_q    <= '0;
            key_q   <= '0;
            hold_q  <= 16'd1;
            lfsr_q  <= 8'hA5;
            row_q   <= 4'hF;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            key_q   <= key_d;
            hold_q  <= hold_d;
            lfsr_q  <= lfsr_d;
            row_q   <= row_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign row       = row_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator at TICK_DIV=10: a clean-contact instance (u0)
// and a bouncing instance (u1), each with its own reset.
module tb_keypad_emulator;

    logic        clk = 1'b0;
    logic        rst0_n, rst1_n;
    logic        v0, v1;
    logic [3:0]  key0, key1;
    logic [15:0] hold0, hold1;
    logic [3:0]  col;
    logic [3:0]  row0, row1;
    logic        rdy0, rdy1, busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    keypad_emulator #(.TICK_DIV(10), .BOUNCE_EN(0), .BOUNCE_MS(4), .GAP_MS(30)) u0 (
        .sys_clk(clk), .rst_n(rst0_n), .cmd_valid(v0), .cmd_ready(rdy0),
        .cmd_key(key0), .cmd_hold_ms(hold0), .col(col), .row(row0),
        .busy(busy0), .done(done0)
    );

    keypad_emulator #(.TICK_DIV(10), .BOUNCE_EN(1), .BOUNCE_MS(4), .GAP_MS(30)) u1 (
        .sys_clk(clk), .rst_n(rst1_n), .cmd_valid(v1), .cmd_ready(rdy1),
        .cmd_key(key1), .cmd_hold_ms(hold1), .col(col), .row(row1),
        .busy(busy1), .done(done1)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    // cyc numbers the clock cycle being observed; the cycle right after the accept edge is 1.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic issue(input bit sel, input logic [3:0] k, input logic [15:0] h);
        if (sel) begin key1 = k; hold1 = h; v1 = 1'b1; end
        else     begin key0 = k; hold0 = h; v0 = 1'b1; end
        @(posedge clk);
        #1;
        v0  = 1'b0;
        v1  = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input bit sel, input int limit, output int at);
        at = -1;
        while (cyc <= limit) begin
            if (sel ? done1 : done0) begin
                at = cyc;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset;
        checks++; if (row0 !== 4'hF) begin errors++; $display("FAIL reset_row0 got %h exp %h", row0, 4'hF); end
        checks++; if (row1 !== 4'hF) begin errors++; $display("FAIL reset_row1 got %h exp %h", row1, 4'hF); end
        checks++; if ({rdy0, busy0, done0} !== 3'b100) begin errors++; $display("FAIL reset_ctl0 got %b exp 100", {rdy0, busy0, done0}); end
        checks++; if ({rdy1, busy1, done1} !== 3'b100) begin errors++; $display("FAIL reset_ctl1 got %b exp 100", {rdy1, busy1, done1}); end
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        step(3);
        checks++; if ({row0, rdy0, busy0} !== 6'b1111_10) begin errors++; $display("FAIL post_reset0 got %b exp 111110", {row0, rdy0, busy0}); end
    endtask

    task automatic test_clean_press;
        int at;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL t1_ready got %b exp 1", rdy0); end
        issue(0, 4'h5, 16'd100);
        step(20);
        col = 4'b1101; step(1);
        checks++; if (row0 !== 4'b1011) begin errors++; $display("FAIL t1_col1101 got %b exp 1011", row0); end
        col = 4'b0000; step(1);
        checks++; if (row0 !== 4'b1011) begin errors++; $display("FAIL t1_col0000 got %b exp 1011", row0); end
        col = 4'b1110; step(1);
        checks++; if (row0 !== 4'hF) begin errors++; $display("FAIL t1_col1110 got %b exp 1111", row0); end
        col = 4'b0000;
        wait_done(0, 1400, at);
        checks++; if (at !== 1300) begin errors++; $display("FAIL t1_done_cycle got %0d exp 1300", at); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL t1_busy_at_done got %b exp 1", busy0); end
        step(1);
        checks++; if ({done0, busy0, rdy0} !== 3'b001) begin errors++; $display("FAIL t1_after_done got %b exp 001", {done0, busy0, rdy0}); end
    endtask

    task automatic test_key_sweep;
        int at;
        logic [3:0] low;
        logic [3:0] exp_row;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kk;
            logic [1:0] r;
            kk  = 4'(k);
            r   = 2'd3 - kk[3:2];
            low = ~(4'b0001 << r);
            col = 4'b0000;
            issue(0, kk, 16'd2);
            step(1);
            checks++; if (row0 !== low) begin errors++; $display("FAIL t2_key%0d_col0 got %b exp %b", k, row0, low); end
            for (int b = 0; b < 4; b++) begin
                col = ~(4'b0001 << b);
                step(1);
                exp_row = (b == int'(kk[1:0])) ? low : 4'hF;
                checks++; if (row0 !== exp_row) begin errors++; $display("FAIL t2_key%0d_colbit%0d got %b exp %b", k, b, row0, exp_row); end
            end
            col = 4'b0000;
            wait_done(0, 400, at);
            checks++; if (at !== 320) begin errors++; $display("FAIL t2_key%0d_done got %0d exp 320", k, at); end
            step(1);
        end
    endtask

    task automatic test_bounce;
        int at;
        logic [7:0] m;
        logic [3:0] exp_row;
        m   = 8'hA5;
        col = 4'b0000;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL t3_ready got %b exp 1", rdy1); end
        // key 9: col1, row1 -> closed pattern 1101
        issue(1, 4'h9, 16'd5);
        step(4);
        for (int i = 0; i < 4; i++) begin
            exp_row = m[0] ? 4'b1101 : 4'hF;
            checks++; if (row1 !== exp_row) begin errors++; $display("FAIL t3_bounce_in%0d got %b exp %b", i, row1, exp_row); end
            m = lfsr_next(m);
            step(10);
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (row1 !== 4'b1101) begin errors++; $display("FAIL t3_hold%0d got %b exp 1101", i, row1); end
            step(10);
        end
        for (int i = 0; i < 4; i++) begin
            exp_row = m[0] ? 4'b1101 : 4'hF;
            checks++; if (row1 !== exp_row) begin errors++; $display("FAIL t3_bounce_out%0d got %b exp %b", i, row1, exp_row); end
            m = lfsr_next(m);
            step(10);
        end
        checks++; if (row1 !== 4'hF) begin errors++; $display("FAIL t3_gap got %b exp 1111", row1); end
        wait_done(1, 500, at);
        checks++; if (at !== 430) begin errors++; $display("FAIL t3_done_cycle got %0d exp 430", at); end
        step(1);
    endtask

    task automatic test_busy_ignore;
        int at;
        int pulses;
        col = 4'b0000;
        issue(0, 4'h3, 16'd10);
        step(30);
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL t4_ready_busy got %b exp 0", rdy0); end
        key0 = 4'hA; hold0 = 16'd1; v0 = 1'b1;
        step(5);
        v0 = 1'b0;
        checks++; if (row0 !== 4'b0111) begin errors++; $display("FAIL t4_row_latched got %b exp 0111", row0); end
        wait_done(0, 500, at);
        checks++; if (at !== 400) begin errors++; $display("FAIL t4_done_cycle got %0d exp 400", at); end
        pulses = 0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (done0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL t4_extra_done got %0d exp 0", pulses); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL t4_idle got %b exp 0", busy0); end
        issue(0, 4'h7, 16'd0);
        wait_done(0, 400, at);
        checks++; if (at !== 310) begin errors++; $display("FAIL t4_hold0_done got %0d exp 310", at); end
        step(1);
    endtask

    task automatic test_back_to_back;
        int at;
        for (int n = 0; n < 2; n++) begin
            checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL t6_ready%0d got %b exp 1", n, rdy0); end
            issue(0, 4'(n + 1), 16'd1);
            wait_done(0, 400, at);
            checks++; if (at !== 310) begin errors++; $display("FAIL t6_done%0d got %0d exp 310", n, at); end
            step(1);
        end
    endtask

    task automatic test_async_reset;
        int at;
        col = 4'b0000;
        issue(0, 4'h6, 16'd50);
        step(100);
        checks++; if (row0 !== 4'b1011) begin errors++; $display("FAIL t5_row_before got %b exp 1011", row0); end
        #3;
        rst0_n = 1'b0;
        #1;
        checks++; if (row0 !== 4'hF) begin errors++; $display("FAIL t5_row_async got %b exp 1111", row0); end
        checks++; if ({rdy0, busy0} !== 2'b10) begin errors++; $display("FAIL t5_ctl_async got %b exp 10", {rdy0, busy0}); end
        @(posedge clk);
        #1;
        rst0_n = 1'b1;
        step(2);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL t5_ready_after got %b exp 1", rdy0); end
        issue(0, 4'hD, 16'd1);
        step(1);
        // key D: col1, row0 -> 1110
        checks++; if (row0 !== 4'b1110) begin errors++; $display("FAIL t5_new_row got %b exp 1110", row0); end
        wait_done(0, 400, at);
        checks++; if (at !== 310) begin errors++; $display("FAIL t5_new_done got %0d exp 310", at); end
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        key0 = '0; key1 = '0; hold0 = '0; hold1 = '0;
        col = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_clean_press;
        test_key_sweep;
        test_bounce;
        test_busy_ignore;
        test_back_to_back;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
